e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand width and HI/LO register width.
REQ-002 Parameter MULT_LAT, default 5: busy cycles for mult/multu; legal range 1..63.
REQ-003 Parameter DIV_LAT, default 10: busy cycles for div/divu; legal range 1..63.
REQ-004 clk  input  1  Rising-edge clock; the block's only clock.
REQ-005 reset  input  1  Asynchronous, active-high reset.
REQ-006 start  input  1  Operation strobe from E stage, one cycle per instruction.
REQ-007 md_op  input  3  Operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 a  input  WIDTH  Forwarded rs value.
REQ-009 b  input  WIDTH  Forwarded rt value.
REQ-010 d_is_md  input  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 hi_out  output  WIDTH  Current HI register.
REQ-012 lo_out  output  WIDTH  Current LO register.
REQ-013 busy  output  1  Registered; high while an arithmetic operation is in flight.
REQ-014 md_stall  output  1  Combinational stall request to the stall unit.

Function
REQ-015 The block SHALL hold states IDLE and RUN, with a 6-bit down-counter cnt.
REQ-016 In IDLE with start=1 and md_op in 1..4, the block SHALL latch a, b, and op; load cnt with MULT_LAT or DIV_LAT; and enter RUN on that edge.
REQ-017 busy SHALL equal (state==RUN), going high the cycle after the start edge and staying high for exactly LAT cycles.
REQ-018 In RUN, cnt SHALL decrement each cycle; on the edge where cnt==1, the block SHALL write HI/LO and return to IDLE, so new values are visible the cycle busy falls.
REQ-019 HI/LO SHALL keep their old values throughout RUN.
REQ-020 mult: {HI,LO} SHALL equal the signed 2*WIDTH product; multu: the unsigned 2*WIDTH product.
REQ-021 div/divu: LO SHALL equal the quotient truncated toward zero and HI the remainder, with the remainder taking the sign of the dividend for div.
REQ-022 Divide by zero: HI and LO SHALL stay unchanged; busy SHALL still run for DIV_LAT cycles.
REQ-023 div of the most-negative value by -1: LO SHALL be the most-negative value and HI SHALL be 0.
REQ-024 mthi/mtlo with start=1 in IDLE: HI (resp. LO) SHALL equal a on the next edge, with no busy cycle.
REQ-025 start=1 while busy=1 SHALL be ignored entirely; no state, cnt, HI, or LO change.
REQ-026 start=1 with md_op 0 or 7 SHALL have no effect.
REQ-027 md_stall SHALL equal d_is_md & (busy | (start & md_op in 1..4)), covering the issue cycle.
REQ-028 hi_out and lo_out SHALL be driven directly from the registers (mf* reads via E-stage forwarding, not bypassed internally).
REQ-029 Arithmetic SHALL be computed on the latched operands, so operand inputs changing during RUN have no effect.

Reset
REQ-030 Asynchronous reset SHALL immediately force state=IDLE, cnt=0, busy=0, hi_out=0, and lo_out=0.
REQ-031 Reset during RUN SHALL abort the operation with no HI/LO write after release.
REQ-032 After release, the first start SHALL be accepted on the first rising edge.

Verification
REQ-033 mult a=0xFFFFFFFE (-2), b=3 at edge t: busy high for cycles t+1..t+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 multu a=0xFFFFFFFF, b=2: after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 div a=-7, b=2: busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu a=7, b=0 leaves prior HI/LO unchanged.
REQ-036 During RUN: mtlo a=0x1234 with start=1 is ignored and LO keeps the arithmetic result; with d_is_md=1, md_stall=1 every busy cycle and 0 after.
REQ-037 Reset asserted mid-div at cnt=4: busy=0 and HI=LO=0 immediately, with no later write; a following mthi a=0xA5A5A5A5 gives HI=0xA5A5A5A5 the next cycle.
REQ-038 Parameter sweep WIDTH=16, MULT_LAT=1, DIV_LAT=3: mult -1*-1 gives HI=0x0000, LO=0x0001 after 1 busy cycle, and busy width matches each latency.

Source files
------------

// File: rtl/e_mdu.sv
// HI/LO multiply-divide unit for the E stage: a fixed-latency multicycle
// mult/div engine plus direct mthi/mtlo writes and the D-stage stall request.
module e_mdu #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             d_is_md,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             md_stall
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

  logic [0:0]       state_reg;
  logic [5:0]       cnt_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic is_arith;
  assign is_arith = (md_op >= OP_MULT) && (md_op <= OP_DIVU);

  // Products are formed from pre-extended operands so the low 2*WIDTH bits
  // of a plain multiply give both the signed and unsigned results.
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  assign prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
  assign prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};

  // Signed division runs on magnitudes; the most-negative dividend's
  // magnitude is representable as unsigned, so MIN / -1 falls out as MIN rem 0.
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  assign div_signed = (op_reg == OP_DIV);
  assign a_neg      = div_signed & a_reg[WIDTH-1];
  assign b_neg      = div_signed & b_reg[WIDTH-1];
  assign div_zero   = (b_reg == '0);
  assign div_n      = a_neg ? -a_reg : a_reg;
  assign div_d      = b_neg ? -b_reg : b_reg;
  assign q_u        = div_zero ? '0 : (div_n / div_d);
  assign r_u        = div_zero ? '0 : (div_n % div_d);
  assign quot       = (a_neg ^ b_neg) ? -q_u : q_u;
  assign rem        = a_neg ? -r_u : r_u;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else if (state_reg == IDLE) begin
      if (start) begin
        if (is_arith) begin
          a_reg     <= a;
          b_reg     <= b;
          op_reg    <= md_op;
          cnt_reg   <= ((md_op == OP_MULT) || (md_op == OP_MULTU)) ? MULT_CNT : DIV_CNT;
          state_reg <= RUN;
        end else if (md_op == OP_MTHI) begin
          hi_reg <= a;
        end else if (md_op == OP_MTLO) begin
          lo_reg <= a;
        end
      end
    end else begin
      cnt_reg <= cnt_reg - 6'd1;
      if (cnt_reg == 6'd1) begin
        state_reg <= IDLE;
        case (op_reg)
          OP_MULT:  {hi_reg, lo_reg} <= prod_s;
          OP_MULTU: {hi_reg, lo_reg} <= prod_u;
          OP_DIV, OP_DIVU: begin
            if (!div_zero) begin
              lo_reg <= quot;
              hi_reg <= rem;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy     = (state_reg == RUN);
  assign hi_out   = hi_reg;
  assign lo_out   = lo_reg;
  assign md_stall = d_is_md & (busy | (start & is_arith));

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: a 32-bit default instance and a 16-bit,
// short-latency instance, each with its own expected-result queue.
module tb_e_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, d0, busy0, stall0;
  logic [2:0]  op0;
  logic [31:0] a0, b0, hi0, lo0;
  logic        start1, d1, busy1, stall1;
  logic [2:0]  op1;
  logic [15:0] a1, b1, hi1, lo1;

  e_mdu dut0 (
    .clk(clk), .reset(reset), .start(start0), .md_op(op0), .a(a0), .b(b0),
    .d_is_md(d0), .hi_out(hi0), .lo_out(lo0), .busy(busy0), .md_stall(stall0)
  );

  e_mdu #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .md_op(op1), .a(a1), .b(b1),
    .d_is_md(d1), .hi_out(hi1), .lo_out(lo1), .busy(busy1), .md_stall(stall1)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          len;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [31:0] cur_hi[2];
  logic [31:0] cur_lo[2];
  int  tests = 0;
  int  fails = 0;
  bit  abort0 = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor for the 32-bit instance: results are compared when busy falls.
  int len0 = 0;
  bit hold0 = 1'b1;
  bit pb0 = 1'b0;
  always @(negedge clk) begin
    if (busy0) begin
      len0++;
      if (q0.size() == 0) check("busy0_without_op", {31'b0, busy0}, 32'd0);
      else if (hi0 !== q0[0].old_hi || lo0 !== q0[0].old_lo) hold0 = 1'b0;
    end else if (pb0) begin
      if (q0.size() == 0) begin
        check("busy0_fall_without_op", 32'(q0.size()), 32'd1);
      end else begin
        e0 = q0.pop_front();
        if (abort0) begin
          abort0 = 1'b0;
          $display("[TB] %s aborted by reset", e0.name);
        end else begin
          check({e0.name, "_hi"}, hi0, e0.hi);
          check({e0.name, "_lo"}, lo0, e0.lo);
          check({e0.name, "_busy_len"}, 32'(len0), 32'(e0.len));
          check({e0.name, "_hold"}, {31'b0, hold0}, 32'd1);
          $display("[TB] %s hi=%h lo=%h busy=%0d", e0.name, hi0, lo0, len0);
        end
      end
      len0  = 0;
      hold0 = 1'b1;
    end
    pb0 = busy0;
  end

  // Monitor for the 16-bit instance.
  int len1 = 0;
  bit hold1 = 1'b1;
  bit pb1 = 1'b0;
  always @(negedge clk) begin
    if (busy1) begin
      len1++;
      if (q1.size() == 0) check("busy1_without_op", {31'b0, busy1}, 32'd0);
      else if ({16'b0, hi1} !== q1[0].old_hi || {16'b0, lo1} !== q1[0].old_lo) hold1 = 1'b0;
    end else if (pb1) begin
      if (q1.size() == 0) begin
        check("busy1_fall_without_op", 32'(q1.size()), 32'd1);
      end else begin
        e1 = q1.pop_front();
        check({e1.name, "_hi"}, {16'b0, hi1}, e1.hi);
        check({e1.name, "_lo"}, {16'b0, lo1}, e1.lo);
        check({e1.name, "_busy_len"}, 32'(len1), 32'(e1.len));
        check({e1.name, "_hold"}, {31'b0, hold1}, 32'd1);
        $display("[TB] %s hi=%h lo=%h busy=%0d", e1.name, hi1, lo1, len1);
      end
      len1  = 0;
      hold1 = 1'b1;
    end
    pb1 = busy1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input string name, input logic [31:0] hi,
                      input logic [31:0] lo, input int len);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.len = len;
    e.old_hi = cur_hi[d]; e.old_lo = cur_lo[d];
    cur_hi[d] = hi; cur_lo[d] = lo;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called just after a rising edge; the operation is sampled on the next edge.
  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (d == 0) begin start0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else begin start1 = 1'b1; op1 = op; a1 = a[15:0]; b1 = b[15:0]; end
    cyc(1);
    start0 = 1'b0; op0 = 3'd0; start1 = 1'b0; op1 = 3'd0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (((d == 0) ? busy0 : busy1) && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_op(input int d, input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int len);
    push(d, name, hi, lo, len);
    issue(d, op, a, b);
    wait_idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start0 = 0; op0 = 0; a0 = 0; b0 = 0; d0 = 0;
    start1 = 0; op1 = 0; a1 = 0; b1 = 0; d1 = 0;
    cur_hi[0] = 0; cur_lo[0] = 0; cur_hi[1] = 0; cur_lo[1] = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("reset_hi", hi0, 32'h0);
    check("reset_lo", lo0, 32'h0);
    check("reset_busy", {31'b0, busy0}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cyc(1);

    // mult -2*3 with the issue-cycle stall, per-cycle stall, an ignored
    // mtlo mid-run and operand inputs scrambled after the start edge.
    push(0, "mult_m2x3", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    start0 = 1'b1; op0 = 3'd1; a0 = 32'hFFFFFFFE; b0 = 32'd3; d0 = 1'b1;
    #1 check("stall_issue", {31'b0, stall0}, 32'd1);
    cyc(1);
    start0 = 1'b0; op0 = 3'd0; a0 = 32'h7777_7777; b0 = 32'h1357_9BDF;
    for (int i = 0; i < 5; i++) begin
      check("stall_busy", {31'b0, stall0}, 32'd1);
      if (i == 1) begin start0 = 1'b1; op0 = 3'd6; a0 = 32'h1234; end
      if (i == 2) begin start0 = 1'b0; op0 = 3'd0; end
      cyc(1);
    end
    check("busy_after_mult", {31'b0, busy0}, 32'd0);
    check("stall_after", {31'b0, stall0}, 32'd0);
    d0 = 1'b0;

    run_op(0, "multu_ffffffffx2", 3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    run_op(0, "div_m7d2",        3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(0, "divu_7d0",        3'd4, 32'd7,        32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(0, "div_7dm2",        3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    run_op(0, "div_min_dm1",     3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    run_op(0, "divu_big_d16",    3'd4, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 10);
    run_op(0, "mult_min_x_min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5);

    issue(0, 3'd5, 32'hDEADBEEF, 32'h0);
    check("mthi_hi", hi0, 32'hDEADBEEF);
    check("mthi_lo", lo0, 32'h00000000);
    check("mthi_busy", {31'b0, busy0}, 32'd0);
    issue(0, 3'd6, 32'hCAFEF00D, 32'h0);
    check("mtlo_lo", lo0, 32'hCAFEF00D);
    check("mtlo_hi", hi0, 32'hDEADBEEF);
    $display("[TB] mthi/mtlo hi=%h lo=%h", hi0, lo0);

    issue(0, 3'd0, 32'h1111, 32'h2222);
    issue(0, 3'd7, 32'h3333, 32'h4444);
    cyc(1);
    check("nop_hi", hi0, 32'hDEADBEEF);
    check("nop_lo", lo0, 32'hCAFEF00D);
    check("nop_busy", {31'b0, busy0}, 32'd0);
    $display("[TB] md_op 0/7 ignored");

    // Abort a div at cnt=4 with reset, then restart on the first edge.
    push(0, "div_aborted", cur_hi[0], cur_lo[0], 10);
    issue(0, 3'd3, 32'd100, 32'd7);
    cyc(6);
    abort0 = 1'b1;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy0}, 32'd0);
    check("abort_hi", hi0, 32'h0);
    check("abort_lo", lo0, 32'h0);
    cur_hi[0] = 0; cur_lo[0] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    issue(0, 3'd5, 32'hA5A5A5A5, 32'h0);
    check("post_reset_mthi", hi0, 32'hA5A5A5A5);
    check("post_reset_busy", {31'b0, busy0}, 32'd0);
    cyc(12);
    check("no_late_write_lo", lo0, 32'h0);
    check("no_late_write_hi", hi0, 32'hA5A5A5A5);
    $display("[TB] reset abort hi=%h lo=%h", hi0, lo0);

    run_op(1, "w16_mult_m1xm1",  3'd1, 32'hFFFF, 32'hFFFF, 32'h0000, 32'h0001, 1);
    run_op(1, "w16_multu_ffxff", 3'd2, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h0001, 1);
    run_op(1, "w16_div_m7d2",    3'd3, 32'hFFF9, 32'h0002, 32'hFFFF, 32'hFFFD, 3);
    run_op(1, "w16_divu_ffffd3", 3'd4, 32'hFFFF, 32'h0003, 32'h0000, 32'h5555, 3);

    cyc(3);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
